seq_calc: RTL



---
 rtl/seq_calc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seq_calc.sv
// seq_calc: multi-cycle unsigned arithmetic unit (add/sub/mul/div) behind a
// start/busy/done handshake. Multiply is iterative shift-add and divide is
// iterative restoring, one bit per clock, so area grows linearly with WIDTH.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   x, y         WIDTH-bit operands (dividend / divisor for div)
//   op_sel       00 add, 01 sub, 10 mul, 11 div
//   busy         high while an operation is in flight
//   done         one-cycle pulse when result/flags are valid
//   result       2*WIDTH result; for div {remainder, quotient}
//   carry_out    add carry / sub no-borrow
//   overflow     signed overflow for add/sub
//   div_by_zero  last completed op was a div with y=0
module seq_calc #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [1:0]         op_sel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               overflow,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int M  = WIDTH - 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_FIN} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_x, r_y;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;     // mul: {partial hi, multiplier}; div: {rem, quot}
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_done, r_carry, r_ovf, r_dbz;

  // add/sub share one adder; sub is x + ~y + 1
  logic [WIDTH:0]     w_add, w_sub, w_as;
  logic               w_ovf;
  // shift-add multiply step
  logic [WIDTH:0]     w_mul_sum;
  // restoring divide step; shifted remainder needs one extra bit
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_qbit;

  assign w_add = {1'b0, r_x} + {1'b0, r_y};
  assign w_sub = {1'b0, r_x} + {1'b0, ~r_y} + (WIDTH+1)'(1);
  assign w_as  = r_op[0] ? w_sub : w_add;
  assign w_ovf = r_op[0] ? ((r_x[M] != r_y[M]) && (w_as[M] != r_x[M]))
                         : ((r_x[M] == r_y[M]) && (w_as[M] != r_x[M]));

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_x} : '0);

  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_qbit   = (w_rem_sh >= {1'b0, r_y});
  // the difference is < y when taken, so WIDTH bits suffice
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) begin
        case (op_sel)
          2'b10:   w_next = S_MUL;
          // div by zero needs no iterations: take the single-cycle path
          2'b11:   w_next = (y == '0) ? S_ADDSUB : S_DIV;
          default: w_next = S_ADDSUB;
        endcase
      end
      S_ADDSUB: w_next = S_FIN;
      S_MUL, S_DIV: if (r_cnt == CW'(1)) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_x   <= x;
          r_y   <= y;
          r_op  <= op_sel;
          r_cnt <= CW'(WIDTH);
          r_acc <= (op_sel == 2'b10) ? {{WIDTH{1'b0}}, y} : {{WIDTH{1'b0}}, x};
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_acc <= {(w_qbit ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIN: begin
          r_done <= 1'b1;
          case (r_op)
            2'b10: begin
              r_result <= r_acc;
              r_carry  <= 1'b0;
              r_ovf    <= 1'b0;
              r_dbz    <= 1'b0;
            end
            2'b11: begin
              r_result <= (r_y == '0) ? {r_x, {WIDTH{1'b1}}} : r_acc;
              r_carry  <= 1'b0;
              r_ovf    <= 1'b0;
              r_dbz    <= (r_y == '0);
            end
            default: begin
              r_result <= {{WIDTH{1'b0}}, w_as[WIDTH-1:0]};
              r_carry  <= w_as[WIDTH];
              r_ovf    <= w_ovf;
              r_dbz    <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign result      = r_result;
  assign carry_out   = r_carry;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
endmodule
